// File: rtl/ysyx_210544_mem_arbiter_pkg.sv
// Shared encodings and default widths for the fetch/data memory arbiter.
package ysyx_210544_mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 512;
    localparam int DEF_BLKS_W = 8;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/ysyx_210544_rr_pick2.sv
// Two-way round-robin picker: bit 0 = fetch, bit 1 = data. On a tie the
// requester that was not granted last wins.
module ysyx_210544_rr_pick2
    import ysyx_210544_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last,
    output logic [1:0] gnt
);

    always_comb begin
        // NOTE: gnt gets a default before any branch so no path leaves it unassigned (no latch).
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last == OWN_IF) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/ysyx_210544_mem_arbiter.sv
// Arbitrates fetch and data ports onto the single AXI bridge request port,
// holding one registered transaction at a time and steering the completion back.
module ysyx_210544_mem_arbiter
    import ysyx_210544_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BLKS_W = DEF_BLKS_W
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              if_valid_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic [2:0]        if_size_i,
    input  logic [BLKS_W-1:0] if_blks_i,
    output logic              if_ready_o,
    output logic [DATA_W-1:0] if_rdata_o,

    input  logic              mem_valid_i,
    input  logic              mem_op_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [2:0]        mem_size_i,
    input  logic [BLKS_W-1:0] mem_blks_i,
    output logic              mem_ready_o,
    output logic [DATA_W-1:0] mem_rdata_o,

    output logic              axi_valid_o,
    output logic              axi_op_o,
    output logic [ADDR_W-1:0] axi_addr_o,
    output logic [DATA_W-1:0] axi_wdata_o,
    output logic [2:0]        axi_size_o,
    output logic [BLKS_W-1:0] axi_blks_o,
    input  logic              axi_ready_i,
    input  logic [DATA_W-1:0] axi_rdata_i
);

    state_e            state;
    owner_e            owner;
    owner_e            lastGrant;
    logic [1:0]        gnt;
    logic              arbOpen;
    logic [DATA_W-1:0] rdataBuf;

    // The cycle carrying a ready pulse is skipped so the finishing master's
    // still-high valid is never taken as a fresh request.
    assign arbOpen = ~(if_ready_o | mem_ready_o);

    ysyx_210544_rr_pick2 u_pick (
        .req  ({mem_valid_i, if_valid_i}),
        .last (lastGrant),
        .gnt  (gnt)
    );

    // NOTE: the completion buffer has no reset; it is always written before it is read.
    always_ff @(posedge clock) begin
        if (state == ST_BUSY && axi_ready_i) begin
            rdataBuf <= (owner == OWN_MEM && axi_op_o == OP_WRITE) ? '0 : axi_rdata_i;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            owner       <= OWN_IF;
            lastGrant   <= OWN_IF;
            axi_valid_o <= 1'b0;
            axi_op_o    <= OP_READ;
            axi_addr_o  <= '0;
            axi_wdata_o <= '0;
            axi_size_o  <= '0;
            axi_blks_o  <= '0;
            if_ready_o  <= 1'b0;
            mem_ready_o <= 1'b0;
            if_rdata_o  <= '0;
            mem_rdata_o <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            if_ready_o  <= 1'b0;
            mem_ready_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (arbOpen && gnt != 2'b00) begin
                        state       <= ST_BUSY;
                        axi_valid_o <= 1'b1;
                        if (gnt[1]) begin
                            owner       <= OWN_MEM;
                            lastGrant   <= OWN_MEM;
                            axi_op_o    <= mem_op_i;
                            axi_addr_o  <= mem_addr_i;
                            axi_wdata_o <= mem_wdata_i;
                            axi_size_o  <= mem_size_i;
                            axi_blks_o  <= mem_blks_i;
                        end else begin
                            owner       <= OWN_IF;
                            lastGrant   <= OWN_IF;
                            axi_op_o    <= OP_READ;
                            axi_addr_o  <= if_addr_i;
                            axi_wdata_o <= '0;
                            axi_size_o  <= if_size_i;
                            axi_blks_o  <= if_blks_i;
                        end
                    end
                end
                ST_BUSY: begin
                    if (axi_ready_i) begin
                        state       <= ST_RESP;
                        axi_valid_o <= 1'b0;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    if (owner == OWN_MEM) begin
                        mem_ready_o <= 1'b1;
                        mem_rdata_o <= rdataBuf;
                    end else begin
                        if_ready_o  <= 1'b1;
                        if_rdata_o  <= rdataBuf;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ysyx_210544_mem_arbiter.md
Name: ysyx_210544_mem_arbiter

Overview:
- Two-master arbiter between the CPU core's instruction-fetch port (read-only) and data-memory port (read/write).
- Drives the single user-side request port of the AXI read/write bridge.
- Registers the granted request, holds it stable for the whole bridge transaction, and routes the completion pulse and read data back to the owning master.
- Round-robin arbitration, one outstanding transaction at a time.

Parameters:
ADDR_W, 64, address width
DATA_W, 512, line data width (8 beats x 64 bit)
BLKS_W, 8, burst-length field width (beats minus 1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
if_valid_i  in  1  fetch request
if_addr_i  in  ADDR_W  fetch address
if_size_i  in  3  fetch beat size
if_blks_i  in  BLKS_W  fetch beats-1
if_ready_o  out  1  one-cycle completion pulse to fetch
if_rdata_o  out  DATA_W  fetch read data, valid with if_ready_o
mem_valid_i  in  1  data request
mem_op_i  in  1  0 = read, 1 = write
mem_addr_i  in  ADDR_W  data address
mem_wdata_i  in  DATA_W  write data
mem_size_i  in  3  beat size
mem_blks_i  in  BLKS_W  beats-1
mem_ready_o  out  1  one-cycle completion pulse to data port
mem_rdata_o  out  DATA_W  read data, valid with mem_ready_o
axi_valid_o  out  1  request to bridge
axi_op_o  out  1  0 = read, 1 = write
axi_addr_o  out  ADDR_W  latched address
axi_wdata_o  out  DATA_W  latched write data
axi_size_o  out  3  latched size
axi_blks_o  out  BLKS_W  latched beats-1
axi_ready_i  in  1  bridge completion pulse
axi_rdata_i  in  DATA_W  bridge read data, valid with axi_ready_i

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, last_grant = IF, so MEM wins the first tie.
  - All outputs 0.
- State machine:
  - IDLE -> BUSY:
    - On any valid, pick a winner: if only one is requesting, it wins; if both, the one not equal to last_grant wins.
    - Latch op/addr/wdata/size/blks from the winner. For IF, op is forced to 0 and wdata to 0.
    - Record owner and set last_grant = winner.
    - axi_valid_o = 1 from the next cycle (1-cycle grant latency).
  - BUSY -> RESP:
    - axi_valid_o and all axi_* fields are held constant until axi_ready_i = 1.
    - On axi_ready_i, capture axi_rdata_i into the owner's rdata register and drop axi_valid_o the next cycle.
  - RESP -> IDLE:
    - Owner's ready_o = 1 for exactly one cycle; its rdata_o is stable in that cycle.
    - Arbitration resumes the following cycle.
    - Minimum request-to-ready latency = bridge latency + 2 cycles.
- Masters must hold valid and fields stable until their ready_o. The arbiter samples fields only at grant.
- A master that drops valid while not owner is never granted.
- rdata_o registers hold their value until the next completion for that master. For a write completion, mem_rdata_o = 0.
- axi_ready_i in IDLE or RESP is ignored; no pulse is forwarded.
- Reset asserted mid-BUSY:
  - Immediately return to IDLE and clear axi_valid_o and all ready outputs.
  - The pending transaction is dropped; the bridge is reset by the same signal.
- Simultaneous events:
  - A new valid arriving in the same cycle as axi_ready_i waits; no bypass.
  - A master's valid still high in its own RESP cycle is not treated as a new request. The master must deassert after ready_o, so a re-grant requires valid high in IDLE.

Decomposition:
- Shared package/defines: owner encoding (IF = 0, MEM = 1), state encoding (IDLE/BUSY/RESP), op encoding (READ = 0, WRITE = 1), ADDR_W/DATA_W defaults.
- Round-robin picker as sub-module ysyx_210544_rr_pick2: combinational, inputs req[1:0] and last, outputs gnt[1:0]. Everything else stays in one module.

Test Plan:
- Fetch alone: if_valid = 1, addr = 0x8000_0000, blks = 7; bridge returns ready after 5 cycles with rdata = {8{64'h1122334455667788}} -> axi_valid rises 1 cycle after request; axi_op = 0, axi_addr = 0x8000_0000, axi_blks = 7 held stable; if_ready pulses once, 2 cycles after axi_ready; if_rdata matches.
- Data write: mem_op = 1, addr = 0x8000_1000, wdata = 512'hA5... -> axi_op = 1 and wdata latched; mem_ready pulses once with mem_rdata = 0; if_ready stays 0.
- Contention: both valid in the same cycle after reset -> MEM granted first, IF second. Repeat with both held -> grants alternate IF, MEM, IF.
- Field-stability check: change mem_addr_i while BUSY -> axi_addr_o unchanged until completion.
- Async reset mid-BUSY: drop reset for 1 cycle during the wait -> axi_valid_o, if_ready_o, mem_ready_o go 0 asynchronously. After release, state is IDLE and a new fetch is granted normally.
- Spurious completion: axi_ready_i pulse while IDLE -> no ready_o pulse, rdata registers unchanged.
